// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: single-port SRAM controller with a valid/ready request
// channel, byte-masked writes, a credit-protected read-response FIFO and an
// optional post-reset zero-fill of the whole array.

// Checker: the response FIFO must never be pushed while it is full.
module sram_req_ctrl_chk #(
  parameter int CNT_W      = 3,
  parameter int RESP_DEPTH = 4
) (
  input logic             i_clk,
  input logic             i_rst_n,
  input logic             i_push,
  input logic [CNT_W-1:0] i_count
);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RESP_DEPTH);

  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && (i_count == FULL)));
endmodule

module sram_req_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 14,
  parameter int RESP_DEPTH = 4,
  parameter int INIT_ZERO  = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic [DATA_W/8-1:0] i_req_wstrb,
  output logic                o_resp_valid,
  input  logic                i_resp_ready,
  output logic [DATA_W-1:0]   o_resp_rdata,
  output logic                o_init_done
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam int STRB_W = DATA_W/8;
  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(RESP_DEPTH - 1);
  localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W+1)'(RESP_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Expand active-high byte strobes into active-low per-bit write enables.
  function automatic logic [DATA_W-1:0] f_bweb(input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] bweb;
    for (int i = 0; i < STRB_W; i++) begin
      bweb[8*i +: 8] = {8{~strb[i]}};
    end
    return bweb;
  endfunction

  // Circular-buffer pointer advance, wrapping modulo RESP_DEPTH.
  function automatic logic [PTR_W-1:0] f_ptr_next(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = '0;
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  state_t              r_state;
  logic [ADDR_W-1:0]   r_init_addr;
  logic                r_init_done;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_mem_q;
  logic                r_inflight;
  logic [DATA_W-1:0]   r_fifo [RESP_DEPTH];
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;

  logic                w_init_wr;
  logic                w_accept;
  logic                w_rd_en;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [DATA_W-1:0]   w_mem_bweb;
  logic                w_push;
  logic                w_pop;
  logic [CNT_W:0]      w_credit_used;

  // Credit: FIFO occupancy plus the read still inside the SRAM must leave a
  // free slot. init_done is a registered copy of "in RUN", so ready only
  // depends on flops.
  assign w_credit_used = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign o_req_ready   = r_init_done && (w_credit_used < CREDIT_MAX);
  assign o_init_done   = r_init_done;

  assign w_init_wr   = (r_state == ST_INIT);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_rd_en     = w_accept && !i_req_we;
  assign w_wr_en     = w_init_wr || (w_accept && i_req_we);
  assign w_mem_addr  = w_init_wr ? r_init_addr : i_req_addr;
  assign w_mem_wdata = w_init_wr ? {DATA_W{1'b0}} : i_req_wdata;
  assign w_mem_bweb  = w_init_wr ? {DATA_W{1'b0}} : f_bweb(i_req_wstrb);

  assign w_push       = r_inflight;
  assign o_resp_valid = (r_count != {CNT_W{1'b0}});
  assign w_pop        = o_resp_valid && i_resp_ready;
  assign o_resp_rdata = o_resp_valid ? r_fifo[r_head] : {DATA_W{1'b0}};

  // Control FSM: IDLE -> (INIT zero-fill sweep) -> RUN, RUN held until reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_init_addr <= {ADDR_W{1'b0}};
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= (r_state == ST_RUN);
      case (r_state)
        ST_IDLE: begin
          r_init_addr <= {ADDR_W{1'b0}};
          r_state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
        end
        ST_INIT: begin
          r_init_addr <= r_init_addr + ADDR_W'(1);
          if (r_init_addr == ADDR_LAST) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_INIT;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // SRAM array: masked write and 1-cycle synchronous read; contents are not reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_mem_addr] <= (r_mem[w_mem_addr] & w_mem_bweb) | (w_mem_wdata & ~w_mem_bweb);
    end
    if (w_rd_en) begin
      r_mem_q <= r_mem[w_mem_addr];
    end
  end

  // Read-in-flight flag and response FIFO pointers/occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= 1'b0;
      r_head     <= {PTR_W{1'b0}};
      r_tail     <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
    end else begin
      r_inflight <= w_rd_en;
      if (w_push) begin
        r_tail <= f_ptr_next(r_tail);
      end
      if (w_pop) begin
        r_head <= f_ptr_next(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Response FIFO storage: captures the SRAM output the edge after the read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_tail] <= r_mem_q;
    end
  end

  sram_req_ctrl_chk #(
    .CNT_W      (CNT_W),
    .RESP_DEPTH (RESP_DEPTH)
  ) u_chk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_count (r_count)
  );
endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl (DEPTH=16, RESP_DEPTH=4, INIT_ZERO=1).
// A behavioural model keeps a word array and a queue of expected read data;
// a read accepted in cycle c must be visible on the response port in cycle c+2.
module tb_sram_req_ctrl;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 4;
  localparam int DEPTH      = 16;
  localparam int RESP_DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [3:0]  i_req_addr = 4'd0;
  logic [31:0] i_req_wdata = 32'd0;
  logic [3:0]  i_req_wstrb = 4'd0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b0;
  logic [31:0] o_resp_rdata;
  logic        o_init_done;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int orphan_pops = 0;
  bit model_run = 1'b0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_q [$];
  int          cyc_q [$];
  logic [31:0] got_q [$];
  logic [31:0] want_q [$];

  sram_req_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESP_DEPTH(RESP_DEPTH), .INIT_ZERO(1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_init_done(o_init_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle (called #1 after a rising edge), advance to #1 after the
  // next edge and update the model with what that edge accepted or popped.
  task automatic drive_cycle(input logic v, input logic we, input logic [3:0] a,
                             input logic [31:0] wd, input logic [3:0] ws,
                             input logic rr, output logic acc);
    logic pop;
    i_req_valid = v; i_req_we = we; i_req_addr = a;
    i_req_wdata = wd; i_req_wstrb = ws; i_resp_ready = rr;
    acc = v && o_req_ready;
    pop = o_resp_valid && rr;
    if (pop) begin
      got_q.push_back(o_resp_rdata);
      if (exp_q.size() > 0) begin
        want_q.push_back(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end else begin
        orphan_pops++;
      end
    end
    if (acc && !we) begin
      exp_q.push_back(model_mem[a]);
      cyc_q.push_back(cyc);
    end
    if (acc && we) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) model_mem[a][8*b +: 8] = wd[8*b +: 8];
      end
    end
    @(posedge i_clk); #1;
    cyc++;
    i_req_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n, input logic rr);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, rr, acc);
  endtask

  task automatic clear_model_queues();
    exp_q.delete(); cyc_q.delete(); got_q.delete(); want_q.delete();
  endtask

  task automatic zero_model_mem();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
  endtask

  task automatic test_reset();
    int zeros;
    bit rose;
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_req_ready); end
    n_checks++; if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_resp_valid); end
    n_checks++; if (o_resp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", o_resp_rdata); end
    n_checks++; if (o_init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", o_init_done); end
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    zeros = 0; rose = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idle_cycles(1, 1'b1);
      if (o_req_ready) begin rose = 1'b1; break; end
      zeros++;
    end
    n_checks++; if (!rose || zeros != 17) begin n_fail++; $display("FAIL init_latency: ready low for %0d cycles (rose=%0b) want 17", zeros, rose); end
    n_checks++; if (o_init_done !== 1'b1) begin n_fail++; $display("FAIL init_done: got %b want 1", o_init_done); end
    model_run = 1'b1;
    zero_model_mem();
  endtask

  task automatic test_init_zero();
    logic acc;
    clear_model_queues();
    for (int a = 0; a < DEPTH; a++) begin
      drive_cycle(1'b1, 1'b0, 4'(a), 32'd0, 4'd0, 1'b1, acc);
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL init_read_accept: addr %0d got %b want 1", a, acc); end
    end
    idle_cycles(6, 1'b1);
    n_checks++; if (got_q.size() != DEPTH) begin n_fail++; $display("FAIL init_read_count: got %0d want %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== 32'd0) begin n_fail++; $display("FAIL init_read_data: resp %0d got %h want 00000000", i, got_q[i]); end
    end
  endtask

  task automatic test_strobes();
    logic acc [5];
    clear_model_queues();
    drive_cycle(1'b1, 1'b1, 4'd5, 32'hAABBCCDD, 4'hF, 1'b1, acc[0]);
    drive_cycle(1'b1, 1'b1, 4'd5, 32'h11223344, 4'b0101, 1'b1, acc[1]);
    drive_cycle(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 1'b1, acc[2]);
    idle_cycles(4, 1'b1);
    drive_cycle(1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'h0, 1'b1, acc[3]);
    drive_cycle(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 1'b1, acc[4]);
    idle_cycles(4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (acc[i] !== 1'b1) begin n_fail++; $display("FAIL strobe_accept: req %0d got %b want 1", i, acc[i]); end
    end
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL strobe_count: got %0d want 2", got_q.size()); end
    else begin
      n_checks++; if (got_q[0] !== 32'hAA22CC44) begin n_fail++; $display("FAIL strobe_merge: got %h want AA22CC44", got_q[0]); end
      n_checks++; if (got_q[1] !== 32'hAA22CC44) begin n_fail++; $display("FAIL strobe_zero_mask: got %h want AA22CC44", got_q[1]); end
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    bit exp_v;
    for (int a = 0; a < 8; a++) drive_cycle(1'b1, 1'b1, 4'(a), 32'(a), 4'hF, 1'b1, acc);
    idle_cycles(3, 1'b1);
    clear_model_queues();
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        drive_cycle(1'b1, 1'b0, 4'(k), 32'd0, 4'd0, 1'b1, acc);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: read %0d got %b want 1", k, acc); end
      end else begin
        idle_cycles(1, 1'b1);
      end
      exp_v = (k >= 1) && (k <= 8);
      n_checks++; if (o_resp_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid: step %0d got %b want %b", k, o_resp_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (o_resp_rdata !== 32'(k - 1)) begin n_fail++; $display("FAIL b2b_data: step %0d got %h want %h", k, o_resp_rdata, 32'(k - 1)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int n_acc;
    clear_model_queues();
    n_acc = 0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b1, 1'b0, 4'(k % 8), 32'd0, 4'd0, 1'b0, acc);
      if (acc) n_acc++;
    end
    n_checks++; if (n_acc != RESP_DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", n_acc, RESP_DEPTH); end
    n_checks++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b want 0", o_req_ready); end
    idle_cycles(8, 1'b1);
    n_checks++; if (got_q.size() != RESP_DEPTH) begin n_fail++; $display("FAIL bp_drain_count: got %0d want %0d", got_q.size(), RESP_DEPTH); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== 32'(i)) begin n_fail++; $display("FAIL bp_order: resp %0d got %h want %h", i, got_q[i], 32'(i)); end
    end
    n_checks++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b want 1", o_req_ready); end
  endtask

  task automatic test_full_minus_one();
    logic acc;
    bit exp_rdy;
    logic [3:0] a;
    for (int i = 8; i < 16; i++) drive_cycle(1'b1, 1'b1, 4'(i), $urandom, 4'hF, 1'b1, acc);
    idle_cycles(3, 1'b1);
    clear_model_queues();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 4'(8 + i), 32'd0, 4'd0, 1'b0, acc);
    idle_cycles(2, 1'b0);
    n_checks++; if (o_req_ready !== 1'b1) begin n_fail++; $display("FAIL fm1_ready: got %b want 1", o_req_ready); end
    for (int k = 0; k < 12; k++) begin
      exp_rdy = model_run && (exp_q.size() < RESP_DEPTH);
      n_checks++; if (o_req_ready !== exp_rdy) begin n_fail++; $display("FAIL fm1_credit: step %0d got %b want %b", k, o_req_ready, exp_rdy); end
      a = 4'(8 + $urandom_range(0, 7));
      drive_cycle(1'b1, 1'b0, a, 32'd0, 4'd0, 1'b1, acc);
    end
    idle_cycles(8, 1'b1);
    n_checks++; if (exp_q.size() != 0 || orphan_pops != 0) begin n_fail++; $display("FAIL fm1_drain: %0d left, %0d unexpected pops, want 0", exp_q.size(), orphan_pops); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== want_q[i]) begin n_fail++; $display("FAIL fm1_data: resp %0d got %h want %h", i, got_q[i], want_q[i]); end
    end
  endtask

  task automatic test_random();
    logic acc;
    bit exp_rdy, exp_v;
    clear_model_queues();
    for (int k = 0; k < 300; k++) begin
      exp_rdy = model_run && (exp_q.size() < RESP_DEPTH);
      n_checks++; if (o_req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready: cycle %0d got %b want %b", k, o_req_ready, exp_rdy); end
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                  $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, acc);
      exp_v = (cyc_q.size() > 0) && (cyc_q[0] + 2 <= cyc);
      n_checks++; if (o_resp_valid !== exp_v) begin n_fail++; $display("FAIL rnd_valid: cycle %0d got %b want %b", k, o_resp_valid, exp_v); end
    end
    idle_cycles(8, 1'b1);
    n_checks++; if (exp_q.size() != 0 || orphan_pops != 0) begin n_fail++; $display("FAIL rnd_drain: %0d left, %0d unexpected pops, want 0", exp_q.size(), orphan_pops); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== want_q[i]) begin n_fail++; $display("FAIL rnd_data: resp %0d got %h want %h", i, got_q[i], want_q[i]); end
    end
  endtask

  task automatic test_reset_midway();
    logic acc;
    int zeros;
    bit rose;
    clear_model_queues();
    drive_cycle(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, acc);
    drive_cycle(1'b1, 1'b0, 4'd1, 32'd0, 4'd0, 1'b0, acc);
    idle_cycles(2, 1'b0);
    n_checks++; if (o_resp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b want 1", o_resp_valid); end
    i_rst_n = 1'b0;
    #1;
    n_checks++; if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", o_resp_valid); end
    n_checks++; if (o_resp_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_reset_rdata: got %h want 0", o_resp_rdata); end
    n_checks++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0", o_req_ready); end
    model_run = 1'b0;
    clear_model_queues();
    idle_cycles(2, 1'b1);
    i_rst_n = 1'b1;
    idle_cycles(8, 1'b1);
    n_checks++; if (o_req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_init_ready: got %b want 0", o_req_ready); end
    i_rst_n = 1'b0;
    idle_cycles(2, 1'b1);
    i_rst_n = 1'b1;
    zeros = 0; rose = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idle_cycles(1, 1'b1);
      n_checks++; if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_resp: cycle %0d got %b want 0", i, o_resp_valid); end
      if (o_req_ready) begin rose = 1'b1; break; end
      zeros++;
    end
    n_checks++; if (!rose || zeros != 17) begin n_fail++; $display("FAIL reinit_latency: ready low for %0d cycles (rose=%0b) want 17", zeros, rose); end
    model_run = 1'b1;
    zero_model_mem();
    idle_cycles(4, 1'b1);
    n_checks++; if (o_resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_late: got %b want 0", o_resp_valid); end
    test_init_zero();
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_strobes();
    test_back_to_back();
    test_backpressure();
    test_full_minus_one();
    test_random();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
